// File: rtl/load_writeback_unit.sv
// Load/writeback unit: issues one aligned load at a time, extends the returned lane and writes it back.
// With LOAD_TIMEOUT_EN defined, a load that waits TIMEOUT_CYCLES cycles for data is abandoned.
module load_writeback_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic [4:0]  req_rd,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic [63:0] memory_address,
    output logic        mem_req,
    input  logic [63:0] memory_data,
    input  logic        data_ready,
    output logic [4:0]  write_reg,
    output logic        reg_write,
    output logic [63:0] write_data,
    output logic        busy,
    output logic        load_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } state_t;

    state_t      state, state_next;
    logic        err_q, err_next;
    logic [63:0] addr_q;
    logic [4:0]  rd_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        accept;
    logic        aligned;
    logic        timeout;
    logic        capture;
    logic [63:0] lane;
    logic [63:0] ext_data;

    assign accept  = req_valid && (state == IDLE);
    assign capture = (state == WAIT) && data_ready;

    always_comb begin
        case (req_size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = (req_addr[0] == 1'b0);
            2'd2:    aligned = (req_addr[1:0] == 2'b00);
            default: aligned = (req_addr[2:0] == 3'b000);
        endcase
    end

`ifdef LOAD_TIMEOUT_EN
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;

    // Counts completed WAIT cycles; cleared whenever the unit is not waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= 8'd0;
        else if (state != WAIT)
            wait_cnt <= 8'd0;
        else
            wait_cnt <= wait_cnt + 8'd1;
    end

    assign timeout = (wait_cnt == WAIT_LAST);
`else
    assign timeout = 1'b0;
`endif

    // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (aligned)
                        state_next = ISSUE;
                    else
                        err_next = 1'b1;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (data_ready) begin
                    state_next = WB;
                end else if (timeout) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end
            end
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= err_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q   <= 64'd0;
            rd_q     <= 5'd0;
            size_q   <= 2'd0;
            signed_q <= 1'b0;
        end else if (accept) begin
            addr_q   <= req_addr;
            rd_q     <= req_rd;
            size_q   <= req_size;
            signed_q <= req_signed;
        end
    end

    // Shift the addressed byte lane down to bit 0, then extend by size.
    assign lane = memory_data >> {addr_q[2:0], 3'b000};

    always_comb begin
        case (size_q)
            2'd0:    ext_data = {{56{signed_q & lane[7]}},  lane[7:0]};
            2'd1:    ext_data = {{48{signed_q & lane[15]}}, lane[15:0]};
            2'd2:    ext_data = {{32{signed_q & lane[31]}}, lane[31:0]};
            default: ext_data = memory_data;
        endcase
    end

    // Write port registers only change for a real write, so they hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_data <= 64'd0;
            write_reg  <= 5'd0;
        end else if (capture && (rd_q != 5'd0)) begin
            write_data <= ext_data;
            write_reg  <= rd_q;
        end
    end

    assign req_ready      = (state == IDLE);
    assign busy           = (state != IDLE);
    assign mem_req        = (state == ISSUE);
    assign reg_write      = (state == WB) && (rd_q != 5'd0);
    assign memory_address = {addr_q[63:3], 3'b000};
    assign load_error     = err_q;

endmodule

// File: doc/load_writeback_unit.md
LOAD_WRITEBACK_UNIT -- requirements
Module: load_writeback_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: number of WAIT cycles allowed before a load is abandoned (range 2-255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: a load request is present.
REQ-005 SHALL have port req_ready, output, 1 bit: the unit can accept a request.
REQ-006 SHALL have port req_addr, input, 64 bits: byte address of the load.
REQ-007 SHALL have port req_rd, input, 5 bits: destination register index.
REQ-008 SHALL have port req_size, input, 2 bits: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-009 SHALL have port req_signed, input, 1 bit: 1 = sign-extend, 0 = zero-extend.
REQ-010 SHALL have port memory_address, output, 64 bits: address presented to the memory load stage.
REQ-011 SHALL have port mem_req, output, 1 bit: one-cycle load strobe to the memory load stage.
REQ-012 SHALL have port memory_data, input, 64 bits: data returned by the memory load stage.
REQ-013 SHALL have port data_ready, input, 1 bit: memory_data is valid this cycle.
REQ-014 SHALL have ports write_reg (output, 5 bits), reg_write (output, 1 bit) and write_data (output, 64 bits): the register file write port.
REQ-015 SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-016 SHALL have port load_error, output, 1 bit: one-cycle pulse when a load is abandoned.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT and WB; req_ready = 1 only in IDLE.
REQ-018 SHALL accept a request when req_valid && req_ready, and register addr, rd, size and signed at that edge.
REQ-019 SHALL, on accept, move IDLE->ISSUE if the request is aligned, i.e. addr[0] = 0 for half, addr[1:0] = 0 for word, addr[2:0] = 0 for double.
REQ-020 SHALL, on a misaligned accept, stay in IDLE, pulse load_error the next cycle, and assert neither mem_req nor reg_write.
REQ-021 SHALL, in ISSUE, drive memory_address = {addr[63:3], 3'b000} with mem_req = 1 for exactly one cycle, then go to WAIT.
REQ-022 SHALL hold memory_address stable from ISSUE through the end of WAIT.
REQ-023 SHALL, in WAIT, capture memory_data on the first cycle data_ready = 1 and go to WB.
REQ-024 SHALL select the lane at byte offset addr[2:0] and extend it to 64 bits per req_size/req_signed; double passes memory_data unchanged.
REQ-025 SHALL, in WB, assert reg_write for exactly one cycle with write_reg = rd and the extended data, then return to IDLE.
REQ-026 SHALL suppress reg_write when rd = 0 (WB still occupies one cycle).
REQ-027 SHALL give an aligned load with data_ready already high a latency of 3 cycles from the accept edge to the reg_write edge (ISSUE, WAIT, WB).
REQ-028 SHALL ignore data_ready outside WAIT.
REQ-029 SHALL hold write_data and write_reg at their last values when reg_write = 0, and drive mem_req and reg_write to 0 in every state not named above.

Reset
REQ-030 SHALL, on reset assertion at any time (including mid-load), go to IDLE immediately.
REQ-031 SHALL reset outputs to: req_ready = 1, memory_address = 0, mem_req = 0, write_reg = 0, reg_write = 0, write_data = 0, busy = 0, load_error = 0.
REQ-032 SHALL discard a load in progress at reset; no write occurs after reset deasserts.

Configuration
REQ-033 SHALL, with LOAD_TIMEOUT_EN defined, count WAIT cycles; after TIMEOUT_CYCLES cycles without data_ready it SHALL go to IDLE, pulse load_error for one cycle and not write.
REQ-034 SHALL, without LOAD_TIMEOUT_EN, wait in WAIT indefinitely; load_error then arises only from misalignment.

Verification
REQ-035 Aligned signed byte load: addr=0x13, rd=5, size=0, signed=1, memory_data=0x0000_0000_0000_8000_0000 with byte 3 = 0x80, data_ready high -> mem_req with memory_address=0x10; 3 cycles after accept, reg_write=1, write_reg=5, write_data=0xFFFF_FFFF_FFFF_FF80.
REQ-036 Unsigned half load: addr=0x0A, size=1, signed=0, halfword at offset 2 = 0xBEEF -> write_data=0x0000_0000_0000_BEEF.
REQ-037 Misaligned word load: addr=0x06, size=2 -> load_error pulses 1 cycle after accept; mem_req=0, reg_write=0; req_ready stays 1.
REQ-038 Load with rd=0: double load, data_ready high -> full ISSUE/WAIT/WB sequence, reg_write stays 0.
REQ-039 With LOAD_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, data_ready held 0 -> load_error pulses after 16 WAIT cycles, state returns to IDLE, no write; without the macro, busy stays 1.
REQ-040 Reset asserted during WAIT -> all outputs take reset values asynchronously; data_ready raised after reset deasserts causes no reg_write.
